// File: rtl/vga_frame_sequencer.sv
// rtl/vga_frame_sequencer.sv - VGA timing, pixel coordinates and bouncing-object position sequencer
// Object motion is built only when VGA_OBJ_MOTION_EN is defined; otherwise the object sits at the centre.
module vga_frame_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int OBJ_W    = 64,
  parameter int OBJ_H    = 48,
  parameter int STEP     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic        run,
  output logic [31:0] Cx,
  output logic [31:0] Cy,
  output logic        enable,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [31:0] Ox,
  output logic [31:0] Oy,
  output logic [31:0] Ow,
  output logic [31:0] Oh,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] V_UPD    = 32'(V_ACTIVE - 1);
  localparam logic [31:0] X_CENTRE = 32'((H_ACTIVE - OBJ_W) / 2);
  localparam logic [31:0] Y_CENTRE = 32'((V_ACTIVE - OBJ_H) / 2);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  phase_t      h_state, h_nx;
  phase_t      v_state, v_nx;
  logic [31:0] cx_nx, cy_nx;
  logic        en_nx, hs_nx, vs_nx;
  logic        upd;

  // Phase is a pure function of the count so zero-length porches still decode correctly.
  function automatic phase_t phase_of(input logic [31:0] c, input int act, input int fp,
                                      input int sync);
    phase_t p;
    if (c < 32'(act))                  p = PH_ACTIVE;
    else if (c < 32'(act + fp))        p = PH_FRONT;
    else if (c < 32'(act + fp + sync)) p = PH_SYNC;
    else                               p = PH_BACK;
    return p;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Cx         <= '0;
      Cy         <= '0;
      h_state    <= PH_ACTIVE;
      v_state    <= PH_ACTIVE;
      enable     <= 1'b0;
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      Cx         <= cx_nx;
      Cy         <= cy_nx;
      h_state    <= h_nx;
      v_state    <= v_nx;
      enable     <= en_nx;
      VGA_HS     <= hs_nx;
      VGA_VS     <= vs_nx;
      frame_tick <= upd;
    end
  end

  // Sync/enable are decoded from the next counts so they register alongside Cx/Cy.
  always_comb begin
    cx_nx = Cx;
    cy_nx = Cy;
    h_nx  = h_state;
    v_nx  = v_state;
    en_nx = enable;
    hs_nx = VGA_HS;
    vs_nx = VGA_VS;
    upd   = 1'b0;
    if (pix_en) begin
      if (Cx == H_LAST) begin
        cx_nx = '0;
        cy_nx = (Cy == V_LAST) ? '0 : Cy + 32'd1;
        upd   = (Cy == V_UPD);
      end else begin
        cx_nx = Cx + 32'd1;
      end
      h_nx  = phase_of(cx_nx, H_ACTIVE, H_FP, H_SYNC);
      v_nx  = phase_of(cy_nx, V_ACTIVE, V_FP, V_SYNC);
      hs_nx = (h_nx != PH_SYNC);
      vs_nx = (v_nx != PH_SYNC);
      en_nx = (h_nx == PH_ACTIVE) && (v_nx == PH_ACTIVE);
    end
  end

  assign Ow = 32'(OBJ_W);
  assign Oh = 32'(OBJ_H);

`ifdef VGA_OBJ_MOTION_EN
  localparam logic [31:0] X_MAX  = 32'(H_ACTIVE - OBJ_W);
  localparam logic [31:0] Y_MAX  = 32'(V_ACTIVE - OBJ_H);
  localparam logic [31:0] STEP_U = 32'(STEP);

  logic        dx, dy, dx_nx, dy_nx;
  logic [31:0] ox_nx, oy_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Ox <= X_CENTRE;
      Oy <= Y_CENTRE;
      dx <= 1'b1;
      dy <= 1'b1;
    end else begin
      Ox <= ox_nx;
      Oy <= oy_nx;
      dx <= dx_nx;
      dy <= dy_nx;
    end
  end

  // Moving towards zero compares before subtracting, so the position never wraps.
  always_comb begin
    ox_nx = Ox;
    oy_nx = Oy;
    dx_nx = dx;
    dy_nx = dy;
    if (upd && run) begin
      if (dx) begin
        if (Ox + STEP_U >= X_MAX) begin
          ox_nx = X_MAX;
          dx_nx = 1'b0;
        end else begin
          ox_nx = Ox + STEP_U;
        end
      end else if (Ox <= STEP_U) begin
        ox_nx = '0;
        dx_nx = 1'b1;
      end else begin
        ox_nx = Ox - STEP_U;
      end
      if (dy) begin
        if (Oy + STEP_U >= Y_MAX) begin
          oy_nx = Y_MAX;
          dy_nx = 1'b0;
        end else begin
          oy_nx = Oy + STEP_U;
        end
      end else if (Oy <= STEP_U) begin
        oy_nx = '0;
        dy_nx = 1'b1;
      end else begin
        oy_nx = Oy - STEP_U;
      end
    end
  end
`else
  logic unused_run;

  assign Ox         = X_CENTRE;
  assign Oy         = Y_CENTRE;
  assign unused_run = run;
`endif

endmodule
